prog_store_loader: RTL



---
 rtl/prog_store_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/prog_store_loader.sv
// Writable 16x8 program store feeding the 4-bit CPU; loads bytes from pin strobes while holding the core in reset.
// instr is combinational from address; writes commit SYNC_STAGES+1 clocks after a strobe rise, no backpressure.
module prog_store_loader #(
  parameter int SYNC_STAGES    = 2,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       load_en,
  input  logic       wr_strobe,
  input  logic [7:0] wr_data,
  input  logic [3:0] address,
  output logic [7:0] instr,
  output logic       cpu_n_reset,
  output logic [3:0] load_ptr,
  output logic       loading,
  output logic       full
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] ls_sync_q, ls_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   ss_dly_q, ss_dly_d;
  logic                   ls, ss, strobe_edge;

  logic [1:0]       state_q, state_d;
  logic [3:0]       load_ptr_q, load_ptr_d;
  logic             full_q, full_d;
  logic             cpu_n_reset_q, cpu_n_reset_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mem_q [16];
  logic [7:0]       mem_d [16];

  always_comb begin
    ls_sync_d   = {ls_sync_q[SYNC_STAGES-2:0], load_en};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], wr_strobe};
    ls          = ls_sync_q[SYNC_STAGES-1];
    ss          = ss_sync_q[SYNC_STAGES-1];
    ss_dly_d    = ss;
    strobe_edge = ss & ~ss_dly_q;
  end

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    full_d     = full_q;
    cnt_d      = '0;
    mem_d      = mem_q;
    case (state_q)
      ST_RUN: begin
        if (ls) begin
          state_d    = ST_LOAD;
          load_ptr_d = 4'd0;
          full_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        // A write landing in the same cycle as load_en falling still commits.
        if (strobe_edge) begin
          mem_d[load_ptr_q] = wr_data;
          load_ptr_d        = load_ptr_q + 4'd1;
          if (load_ptr_q == 4'd15) begin
            full_d  = 1'b1;
            state_d = ST_FULL;
          end
        end
        if (!ls) state_d = ST_RELEASE;
      end
      ST_FULL: begin
        if (!ls) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (ls) begin
          state_d    = ST_LOAD;
          load_ptr_d = 4'd0;
          full_d     = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    cpu_n_reset_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ls_sync_q     <= '0;
      ss_sync_q     <= '0;
      ss_dly_q      <= 1'b0;
      state_q       <= ST_RUN;
      load_ptr_q    <= 4'd0;
      full_q        <= 1'b0;
      cpu_n_reset_q <= 1'b0;
      cnt_q         <= '0;
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else begin
      ls_sync_q     <= ls_sync_d;
      ss_sync_q     <= ss_sync_d;
      ss_dly_q      <= ss_dly_d;
      state_q       <= state_d;
      load_ptr_q    <= load_ptr_d;
      full_q        <= full_d;
      cpu_n_reset_q <= cpu_n_reset_d;
      cnt_q         <= cnt_d;
      for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
    end
  end

  // The held core only ever sees NOPs, never a half-written program.
  assign instr       = (state_q == ST_RUN) ? mem_q[address] : 8'h00;
  assign cpu_n_reset = cpu_n_reset_q;
  assign load_ptr    = load_ptr_q;
  assign loading     = (state_q == ST_LOAD) || (state_q == ST_FULL);
  assign full        = full_q;

endmodule
